ofm_wbuf: RTL and testbench



---
 rtl/ofm_wbuf.sv | 150 +++++++++++++++
 tb/tb_ofm_wbuf.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_wbuf.sv
// OFM buffer write controller: joins the DMA address and data streams and writes
// each beat into the OFM SRAM, either overwriting or accumulating lane-wise.
module ofm_wbuf #(
  parameter int DW = 144,
  parameter int AW = 11,
  parameter int EW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_acc_i,
  input  logic [AW-1:0] addr_i,
  input  logic          addr_first_i,
  input  logic          addr_last_i,
  input  logic          addr_valid_i,
  output logic          addr_ready_o,
  input  logic [DW-1:0] data_i,
  input  logic          data_first_i,
  input  logic          data_last_i,
  input  logic          data_valid_i,
  output logic          data_ready_o,
  output logic          ram_re_o,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          done_valid_o,
  input  logic          done_ready_i,
  output logic [15:0]   done_cnt_o,
  output logic          err_o
);

  localparam int LANES = DW / EW;

  typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT} state_e;

  state_e        state_q, state_d;
  logic          acc_q;
  logic          s2_valid_q;
  logic [AW-1:0] s2_addr_q;
  logic [DW-1:0] s2_data_q;
  logic          s2_last_q;
  logic          s2_acc_q;
  logic          fwd_q;
  logic [DW-1:0] fwd_data_q;
  logic [15:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]   done_cnt_q, done_cnt_d;
  logic          err_q;

  logic          block;
  logic          accept;
  logic          mode_s1;
  logic          fwd_d;
  logic [DW-1:0] old_data;
  logic [DW-1:0] sum_data;

  // A new frame may not start while the previous completion is still pending.
  always_comb begin
    block    = (state_q == DONE_WAIT) && addr_first_i;
    accept   = addr_valid_i && data_valid_i && !block;
    mode_s1  = addr_first_i ? cfg_acc_i : acc_q;
    ram_re_o = accept && mode_s1;
    ram_raddr_o = ram_re_o ? addr_i : '0;
    fwd_d    = ram_re_o && s2_valid_q && (s2_addr_q == addr_i);
  end

  assign addr_ready_o = accept;
  assign data_ready_o = accept;

  // The SRAM returns stale data on read-during-write, so a same-address
  // accumulate right behind a write takes the value just written instead.
  always_comb begin
    old_data = fwd_q ? fwd_data_q : ram_rdata_i;
    sum_data = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_data[i*EW +: EW] = old_data[i*EW +: EW] + s2_data_q[i*EW +: EW];
    end
    ram_we_o    = s2_valid_q;
    ram_waddr_o = s2_valid_q ? s2_addr_q : '0;
    ram_wdata_o = '0;
    if (s2_valid_q) begin
      ram_wdata_o = s2_acc_q ? sum_data : s2_data_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    done_cnt_d = done_cnt_q;
    if (s2_valid_q) begin
      if (s2_last_q) begin
        beat_cnt_d = '0;
        done_cnt_d = beat_cnt_q + 16'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end
    case (state_q)
      IDLE:      if (accept) state_d = RUN;
      RUN:       state_d = RUN;
      DONE_WAIT: if (done_ready_i) state_d = accept ? RUN : IDLE;
      default:   state_d = IDLE;
    endcase
    // Writing the last beat always (re)arms completion, even over an acknowledge.
    if (s2_valid_q && s2_last_q) begin
      state_d = DONE_WAIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_acc_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      beat_cnt_q <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      done_cnt_q <= done_cnt_d;
      s2_valid_q <= accept;
      fwd_q      <= fwd_d;
      fwd_data_q <= ram_wdata_o;
      if (accept) begin
        s2_addr_q <= addr_i;
        s2_data_q <= data_i;
        s2_last_q <= addr_last_i;
        s2_acc_q  <= mode_s1;
        if (addr_first_i) begin
          acc_q <= cfg_acc_i;
        end
        if ((addr_first_i != data_first_i) || (addr_last_i != data_last_i)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign done_valid_o = (state_q == DONE_WAIT);
  assign done_cnt_o   = done_cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ofm_wbuf.sv
// Directed self-checking bench for ofm_wbuf with a behavioural OFM SRAM
// that returns old data on read-during-write.
module tb_ofm_wbuf;

  localparam int DW = 144;
  localparam int AW = 11;
  localparam int EW = 16;
  localparam int LANES = DW / EW;

  logic          clk;
  logic          rst;
  logic          cfgAcc;
  logic [AW-1:0] addr;
  logic          addrFirst, addrLast, addrValid;
  logic          addrReady;
  logic [DW-1:0] data;
  logic          dataFirst, dataLast, dataValid;
  logic          dataReady;
  logic          ramRe;
  logic [AW-1:0] ramRaddr;
  logic [DW-1:0] ramRdata;
  logic          ramWe;
  logic [AW-1:0] ramWaddr;
  logic [DW-1:0] ramWdata;
  logic          doneValid;
  logic          doneReady;
  logic [15:0]   doneCnt;
  logic          err;

  logic          preWe;
  logic [AW-1:0] preAddr;
  logic [DW-1:0] preData;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int testsRun;
  int failCount;

  ofm_wbuf #(.DW(DW), .AW(AW), .EW(EW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_acc_i    (cfgAcc),
    .addr_i       (addr),
    .addr_first_i (addrFirst),
    .addr_last_i  (addrLast),
    .addr_valid_i (addrValid),
    .addr_ready_o (addrReady),
    .data_i       (data),
    .data_first_i (dataFirst),
    .data_last_i  (dataLast),
    .data_valid_i (dataValid),
    .data_ready_o (dataReady),
    .ram_re_o     (ramRe),
    .ram_raddr_o  (ramRaddr),
    .ram_rdata_i  (ramRdata),
    .ram_we_o     (ramWe),
    .ram_waddr_o  (ramWaddr),
    .ram_wdata_o  (ramWdata),
    .done_valid_o (doneValid),
    .done_ready_i (doneReady),
    .done_cnt_o   (doneCnt),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple-dual-port SRAM; the bench can also preload it through its own port.
  always @(posedge clk) begin
    if (ramWe) mem[ramWaddr] <= ramWdata;
    else if (preWe) mem[preAddr] <= preData;
    if (ramRe) ramRdata <= mem[ramRaddr];
  end

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    addrValid = 1'b0; dataValid = 1'b0;
    addrFirst = 1'b0; addrLast = 1'b0;
    dataFirst = 1'b0; dataLast = 1'b0;
    cfgAcc = 1'b0; addr = '0; data = '0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic af, input logic al, input logic df,
                               input logic dl, input logic acc);
    addr = a; data = d;
    addrFirst = af; addrLast = al;
    dataFirst = df; dataLast = dl;
    cfgAcc = acc;
    addrValid = 1'b1; dataValid = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    preWe = 1'b1; preAddr = a; preData = d;
    tick();
    preWe = 1'b0;
  endtask

  task automatic ackDone();
    doneReady = 1'b1;
    tick();
    doneReady = 1'b0;
  endtask

  task automatic checkWrite(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    checkOutput({tag, "_we"}, DW'(ramWe), DW'(1'b1));
    checkOutput({tag, "_waddr"}, DW'(ramWaddr), DW'(a));
    checkOutput({tag, "_wdata"}, ramWdata, d);
  endtask

  initial begin
    testsRun = 0;
    failCount = 0;
    rst = 1'b1;
    doneReady = 1'b0;
    preWe = 1'b0; preAddr = '0; preData = '0;
    idleInputs();
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_ready", DW'(addrReady), DW'(1'b0));
    checkOutput("rst_re", DW'(ramRe), DW'(1'b0));
    checkOutput("rst_we", DW'(ramWe), DW'(1'b0));
    checkOutput("rst_waddr", DW'(ramWaddr), DW'(0));
    checkOutput("rst_wdata", ramWdata, '0);
    checkOutput("rst_done", DW'(doneValid), DW'(1'b0));
    checkOutput("rst_cnt", DW'(doneCnt), DW'(0));
    checkOutput("rst_err", DW'(err), DW'(1'b0));
    tick();

    // Overwrite frame of four beats, data (k+1)*0x11 in every lane.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(AW'(k), rep(16'((k + 1) * 17)), k == 0, k == 3, k == 0, k == 3, 1'b0);
      @(negedge clk);
      checkOutput("ow_ready", DW'(dataReady), DW'(1'b1));
      checkOutput("ow_re", DW'(ramRe), DW'(1'b0));
      if (k > 0) checkWrite("ow", AW'(k - 1), rep(16'(k * 17)));
      tick();
    end
    idleInputs();
    @(negedge clk);
    checkWrite("ow_last", AW'(3), rep(16'h0044));
    checkOutput("ow_done_early", DW'(doneValid), DW'(1'b0));
    tick();
    @(negedge clk);
    checkOutput("ow_done", DW'(doneValid), DW'(1'b1));
    checkOutput("ow_cnt", DW'(doneCnt), DW'(4));
    checkOutput("ow_err", DW'(err), DW'(1'b0));
    checkOutput("ow_we_idle", DW'(ramWe), DW'(1'b0));
    ackDone();
    @(negedge clk);
    checkOutput("ow_ack", DW'(doneValid), DW'(1'b0));
    tick();

    // Accumulate onto preloaded 0x0001; second beat relies on the latched mode.
    preload(AW'(5), rep(16'h0001));
    preload(AW'(6), rep(16'h0001));
    applyStimulus(AW'(5), rep(16'h0002), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("acc_re", DW'(ramRe), DW'(1'b1));
    checkOutput("acc_raddr", DW'(ramRaddr), DW'(5));
    tick();
    applyStimulus(AW'(6), rep(16'h0002), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("acc_re_latched", DW'(ramRe), DW'(1'b1));
    checkWrite("acc5", AW'(5), rep(16'h0003));
    tick();
    idleInputs();
    @(negedge clk);
    checkWrite("acc6", AW'(6), rep(16'h0003));
    tick();
    @(negedge clk);
    checkOutput("acc_cnt", DW'(doneCnt), DW'(2));
    ackDone();

    // Back-to-back accumulate to one address, then a per-lane wrap.
    preload(AW'(7), rep(16'h0000));
    preload(AW'(8), rep(16'hFFFF));
    applyStimulus(AW'(7), rep(16'h0010), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(AW'(7), rep(16'h0010), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkWrite("byp1", AW'(7), rep(16'h0010));
    tick();
    applyStimulus(AW'(8), rep(16'h0002), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("byp2", AW'(7), rep(16'h0020));
    tick();
    idleInputs();
    @(negedge clk);
    checkWrite("wrap", AW'(8), rep(16'h0001));
    tick();
    @(negedge clk);
    checkOutput("byp_cnt", DW'(doneCnt), DW'(3));
    ackDone();

    // Completion back-pressure: the next frame waits for the acknowledge.
    applyStimulus(AW'(20), rep(16'h00AB), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idleInputs();
    tick();
    applyStimulus(AW'(21), rep(16'h00CD), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("blk_done", DW'(doneValid), DW'(1'b1));
    checkOutput("blk_ready0", DW'(addrReady), DW'(1'b0));
    tick();
    @(negedge clk);
    checkOutput("blk_ready1", DW'(addrReady), DW'(1'b0));
    checkOutput("blk_cnt_hold", DW'(doneCnt), DW'(1));
    doneReady = 1'b1;
    #1;
    checkOutput("blk_ack_cycle", DW'(addrReady), DW'(1'b0));
    tick();
    doneReady = 1'b0;
    @(negedge clk);
    checkOutput("blk_release", DW'(addrReady), DW'(1'b1));
    checkOutput("blk_done_clr", DW'(doneValid), DW'(1'b0));
    tick();
    applyStimulus(AW'(22), rep(16'h00EF), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("blk_w21", AW'(21), rep(16'h00CD));
    tick();
    idleInputs();
    @(negedge clk);
    checkWrite("blk_w22", AW'(22), rep(16'h00EF));
    tick();
    @(negedge clk);
    checkOutput("blk_cnt", DW'(doneCnt), DW'(2));
    ackDone();

    // data_last one beat early: framing follows the address stream.
    applyStimulus(AW'(30), rep(16'h0001), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mis_err0", DW'(err), DW'(1'b0));
    tick();
    applyStimulus(AW'(31), rep(16'h0002), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(AW'(32), rep(16'h0003), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mis_err1", DW'(err), DW'(1'b1));
    checkOutput("mis_no_done", DW'(doneValid), DW'(1'b0));
    tick();
    idleInputs();
    @(negedge clk);
    checkWrite("mis_w32", AW'(32), rep(16'h0003));
    tick();
    @(negedge clk);
    checkOutput("mis_done", DW'(doneValid), DW'(1'b1));
    checkOutput("mis_cnt", DW'(doneCnt), DW'(3));
    ackDone();
    @(negedge clk);
    checkOutput("mis_sticky", DW'(err), DW'(1'b1));
    tick();

    // Reset in the middle of a four-beat frame.
    applyStimulus(AW'(40), rep(16'h0040), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(AW'(41), rep(16'h0041), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_we", DW'(ramWe), DW'(1'b0));
    checkOutput("mid_rst_wdata", ramWdata, '0);
    checkOutput("mid_rst_done", DW'(doneValid), DW'(1'b0));
    checkOutput("mid_rst_cnt", DW'(doneCnt), DW'(0));
    checkOutput("mid_rst_err", DW'(err), DW'(1'b0));
    checkOutput("mid_rst_ready", DW'(addrReady), DW'(1'b0));
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(AW'(50 + k), rep(16'(k + 80)), k == 0, k == 2, k == 0, k == 2, 1'b0);
      tick();
    end
    idleInputs();
    tick();
    @(negedge clk);
    checkOutput("post_rst_done", DW'(doneValid), DW'(1'b1));
    checkOutput("post_rst_cnt", DW'(doneCnt), DW'(3));
    checkOutput("post_rst_mem", mem[AW'(52)], rep(16'd82));
    ackDone();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
